// File: rtl/oc4_vc3_cmd_arb_pkg.sv
// Purpose : shared types and helpers for the VC3 command / DCP3 data arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: arbiter state enum, credit counter widths, beats(dl) decode.
package oc4_vc3_cmd_arb_pkg;

    // VC3 initial credit is 4 bits and DCP3 initial credit is 6 bits; one
    // extra bit of headroom keeps the return arithmetic free of wrap.
    localparam int VC_CNT_W = 5;
    localparam int DC_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // 64B beats carried by a command; dl=00 is tolerated as a single beat.
    function automatic logic [2:0] beats(input logic [1:0] dl);
        case (dl)
            2'b10:   beats = 3'd2;
            2'b11:   beats = 3'd4;
            default: beats = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/oc4_credit_cnt.sv
// Purpose : credit counter with load, consume, return and sticky overflow flag.
// Latency : count updates one cycle after load/consume/return.
// Backpressure: none; caller must never consume more than cnt holds.
//
// Ports: clock/reset (sync, active-high); load/load_val set count and limit;
//        consume_amt is subtracted and ret adds one each cycle; cnt is the
//        current count; err is sticky once a return would exceed the limit.
module oc4_credit_cnt #(
    parameter int W   = 5,
    parameter int MAX = 31
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] consume_amt,
    input  logic         ret,
    output logic [W-1:0] cnt,
    output logic         err
);

    logic [W-1:0] limit;
    logic [W-1:0] load_clamped;
    logic [W:0]   after_use;
    logic [W:0]   after_ret;
    logic         ovf;

    assign load_clamped = (load_val > W'(MAX)) ? W'(MAX) : load_val;

    // Consume and return in the same cycle both apply. Because the count
    // never exceeds the limit, an overflow can only come from a return that
    // is not offset by a consume.
    assign after_use = {1'b0, cnt} - {1'b0, consume_amt};
    assign after_ret = after_use + {{W{1'b0}}, ret};
    assign ovf       = ret && (after_ret > {1'b0, limit});

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            limit <= '0;
            err   <= 1'b0;
        end else if (load) begin
            // Returns arriving while loading are discarded.
            cnt   <= load_clamped;
            limit <= load_clamped;
        end else if (ovf) begin
            // Drop the offending return; keep any consume that happened.
            cnt   <= after_use[W-1:0];
            err   <= 1'b1;
        end else begin
            cnt   <= after_ret[W-1:0];
        end
    end

endmodule

// File: rtl/oc4_vc3_cmd_arb.sv
// Purpose : two-requester round-robin arbiter issuing commands on VC3 and
//           write data on DCP3 under TLX credit control.
// Latency : ack in grant cycle T, command on VC3 at T+1; each data beat one
//           cycle after it is presented.
// Backpressure: requesters hold valid until ack; grants stall on missing VC3
//           or DCP3 credit and during a data transfer.
//
// Ports: clock/reset (sync, active-high); tlx_afu_* initial credits and
//        credit-return pulses; req0/req1 command (valid/cmd/dl/has_data/ack)
//        and data beat (data_valid/bus/bdi) inputs; afu_tlx_vc3_* command
//        issue; afu_tlx_dcp3_* data issue; credit_err sticky overflow flag.
module oc4_vc3_cmd_arb
    import oc4_vc3_cmd_arb_pkg::*;
#(
    parameter int CMD_W   = 128,
    parameter int DCP_MAX = 32
) (
    input  logic             clock,
    input  logic             reset,

    input  logic [3:0]       tlx_afu_vc3_initial_credit,
    input  logic [5:0]       tlx_afu_dcp3_initial_credit,
    input  logic             tlx_afu_vc3_credit,
    input  logic             tlx_afu_dcp3_credit,

    input  logic             req0_valid,
    input  logic [CMD_W-1:0] req0_cmd,
    input  logic [1:0]       req0_dl,
    input  logic             req0_has_data,
    output logic             req0_ack,
    input  logic             req0_data_valid,
    input  logic [511:0]     req0_data_bus,
    input  logic             req0_data_bdi,

    input  logic             req1_valid,
    input  logic [CMD_W-1:0] req1_cmd,
    input  logic [1:0]       req1_dl,
    input  logic             req1_has_data,
    output logic             req1_ack,
    input  logic             req1_data_valid,
    input  logic [511:0]     req1_data_bus,
    input  logic             req1_data_bdi,

    output logic             afu_tlx_vc3_valid,
    output logic [CMD_W-1:0] afu_tlx_vc3_cmd,
    output logic             afu_tlx_dcp3_data_valid,
    output logic [511:0]     afu_tlx_dcp3_data_bus,
    output logic             afu_tlx_dcp3_data_bdi,

    output logic             credit_err
);

    localparam int VC_MAX = (1 << VC_CNT_W) - 1;

    arb_state_t          state;
    logic                rr_pref;     // requester favoured on a tie
    logic                data_owner;  // requester whose beats are forwarded
    logic [2:0]          beat_cnt;

    logic [VC_CNT_W-1:0] vc_cnt;
    logic [DC_CNT_W-1:0] dc_cnt;
    logic                vc_err;
    logic                dc_err;

    logic                in_init;
    logic                in_run;
    logic                in_data;
    logic [2:0]          beats0;
    logic [2:0]          beats1;
    logic                elig0;
    logic                elig1;
    logic                grant0;
    logic                grant1;
    logic                grant_any;
    logic                grant_hd;
    logic [2:0]          grant_beats;
    logic [DC_CNT_W-1:0] dc_consume;
    logic                owner_dv;

    // Reset gates the combinational acks so nothing is granted while the
    // state register is still being cleared.
    assign in_init = (state == ST_INIT) && !reset;
    assign in_run  = (state == ST_RUN)  && !reset;
    assign in_data = (state == ST_DATA) && !reset;

    assign beats0 = beats(req0_dl);
    assign beats1 = beats(req1_dl);

    // A data command is only eligible when every beat it needs is covered,
    // so a transfer never stalls half-issued for lack of credit.
    assign elig0 = in_run && req0_valid && (vc_cnt != '0) &&
                   (!req0_has_data || (dc_cnt >= DC_CNT_W'(beats0)));
    assign elig1 = in_run && req1_valid && (vc_cnt != '0) &&
                   (!req1_has_data || (dc_cnt >= DC_CNT_W'(beats1)));

    assign grant0    = elig0 && (!elig1 || !rr_pref);
    assign grant1    = elig1 && (!elig0 ||  rr_pref);
    assign grant_any = grant0 || grant1;

    assign grant_hd    = grant1 ? req1_has_data : req0_has_data;
    assign grant_beats = grant1 ? beats1 : beats0;
    assign dc_consume  = (grant_any && grant_hd) ? DC_CNT_W'(grant_beats) : '0;

    assign req0_ack = grant0;
    assign req1_ack = grant1;

    // Only the granted requester's beats count; everything else is dropped.
    assign owner_dv = in_data && (data_owner ? req1_data_valid : req0_data_valid);

    oc4_credit_cnt #(
        .W   (VC_CNT_W),
        .MAX (VC_MAX)
    ) u_vc_cnt (
        .clock       (clock),
        .reset       (reset),
        .load        (in_init),
        .load_val    (VC_CNT_W'(tlx_afu_vc3_initial_credit)),
        .consume_amt (VC_CNT_W'(grant_any)),
        .ret         (tlx_afu_vc3_credit),
        .cnt         (vc_cnt),
        .err         (vc_err)
    );

    oc4_credit_cnt #(
        .W   (DC_CNT_W),
        .MAX (DCP_MAX)
    ) u_dc_cnt (
        .clock       (clock),
        .reset       (reset),
        .load        (in_init),
        .load_val    (DC_CNT_W'(tlx_afu_dcp3_initial_credit)),
        .consume_amt (dc_consume),
        .ret         (tlx_afu_dcp3_credit),
        .cnt         (dc_cnt),
        .err         (dc_err)
    );

    assign credit_err = vc_err || dc_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= ST_INIT;
            rr_pref                 <= 1'b0;
            data_owner              <= 1'b0;
            beat_cnt                <= '0;
            afu_tlx_vc3_valid       <= 1'b0;
            afu_tlx_vc3_cmd         <= '0;
            afu_tlx_dcp3_data_valid <= 1'b0;
            afu_tlx_dcp3_data_bus   <= '0;
            afu_tlx_dcp3_data_bdi   <= 1'b0;
        end else begin
            afu_tlx_vc3_valid <= grant_any;
            if (grant_any) begin
                afu_tlx_vc3_cmd <= grant1 ? req1_cmd : req0_cmd;
            end

            afu_tlx_dcp3_data_valid <= owner_dv;
            if (owner_dv) begin
                afu_tlx_dcp3_data_bus <= data_owner ? req1_data_bus : req0_data_bus;
                afu_tlx_dcp3_data_bdi <= data_owner ? req1_data_bdi : req0_data_bdi;
            end

            case (state)
                ST_INIT: state <= ST_RUN;
                ST_RUN: begin
                    if (grant_any) begin
                        rr_pref <= ~grant1;
                        if (grant_hd) begin
                            state      <= ST_DATA;
                            beat_cnt   <= grant_beats;
                            data_owner <= grant1;
                        end
                    end
                end
                ST_DATA: begin
                    if (owner_dv) begin
                        beat_cnt <= beat_cnt - 3'd1;
                        if (beat_cnt == 3'd1) begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_oc4_vc3_cmd_arb.sv
// Purpose : self-checking bench for oc4_vc3_cmd_arb against a behavioural model.
// Latency : n/a.
// Backpressure: n/a.
module tb_oc4_vc3_cmd_arb;

    localparam int CMD_W   = 128;
    localparam int DCP_MAX = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset;
    logic [3:0]         tlx_afu_vc3_initial_credit;
    logic [5:0]         tlx_afu_dcp3_initial_credit;
    logic               tlx_afu_vc3_credit;
    logic               tlx_afu_dcp3_credit;

    logic               r_v   [2];
    logic [CMD_W-1:0]   r_cmd [2];
    logic [1:0]         r_dl  [2];
    logic               r_hd  [2];
    logic               r_dv  [2];
    logic [511:0]       r_bus [2];
    logic               r_bdi [2];
    logic               ack0, ack1;

    logic               vc3_vld;
    logic [CMD_W-1:0]   vc3_cmd;
    logic               d_vld;
    logic [511:0]       d_bus;
    logic               d_bdi;
    logic               credit_err;

    oc4_vc3_cmd_arb #(.CMD_W(CMD_W), .DCP_MAX(DCP_MAX)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .tlx_afu_vc3_initial_credit  (tlx_afu_vc3_initial_credit),
        .tlx_afu_dcp3_initial_credit (tlx_afu_dcp3_initial_credit),
        .tlx_afu_vc3_credit          (tlx_afu_vc3_credit),
        .tlx_afu_dcp3_credit         (tlx_afu_dcp3_credit),
        .req0_valid                  (r_v[0]),
        .req0_cmd                    (r_cmd[0]),
        .req0_dl                     (r_dl[0]),
        .req0_has_data               (r_hd[0]),
        .req0_ack                    (ack0),
        .req0_data_valid             (r_dv[0]),
        .req0_data_bus               (r_bus[0]),
        .req0_data_bdi               (r_bdi[0]),
        .req1_valid                  (r_v[1]),
        .req1_cmd                    (r_cmd[1]),
        .req1_dl                     (r_dl[1]),
        .req1_has_data               (r_hd[1]),
        .req1_ack                    (ack1),
        .req1_data_valid             (r_dv[1]),
        .req1_data_bus               (r_bus[1]),
        .req1_data_bdi               (r_bdi[1]),
        .afu_tlx_vc3_valid           (vc3_vld),
        .afu_tlx_vc3_cmd             (vc3_cmd),
        .afu_tlx_dcp3_data_valid     (d_vld),
        .afu_tlx_dcp3_data_bus       (d_bus),
        .afu_tlx_dcp3_data_bdi       (d_bdi),
        .credit_err                  (credit_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus knobs (percentages) per phase.
    int k_req [2];
    int k_hd  [2];
    int k_dl;
    int k_dv;
    int k_vret;
    int k_dret;
    bit k_ovf;

    // Behavioural model: credits as plain integers, data phase as a count of
    // beats still owed, pending outputs as what the wire must show next cycle.
    int m_init, m_vc, m_dc, m_vlim, m_dlim, m_err, m_pref, m_left, m_owner;
    logic               p_vld;
    logic [CMD_W-1:0]   p_cmd;
    logic               p_dvld;
    logic [511:0]       p_dbus;
    logic               p_dbdi;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nb(input logic [1:0] dl);
        return (dl == 2'd3) ? 4 : (dl == 2'd2) ? 2 : 1;
    endfunction

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (!r_v[i] && ($urandom_range(99) < k_req[i])) begin
                r_v[i]   = 1'b1;
                r_cmd[i] = {$urandom, $urandom, $urandom, $urandom};
                r_hd[i]  = ($urandom_range(99) < k_hd[i]);
                r_dl[i]  = (k_dl < 0) ? 2'($urandom_range(3)) : 2'(k_dl);
            end
            r_dv[i] = ($urandom_range(99) < k_dv);
            for (int w = 0; w < 16; w++) r_bus[i][w*32 +: 32] = $urandom;
            r_bdi[i] = 1'($urandom_range(1));
        end
        tlx_afu_vc3_credit  = ($urandom_range(99) < k_vret) && (k_ovf || m_vc < m_vlim);
        tlx_afu_dcp3_credit = ($urandom_range(99) < k_dret) && (k_ovf || m_dc < m_dlim);
    endtask

    task automatic model_reset();
        m_init = 1; m_vc = 0; m_dc = 0; m_vlim = 0; m_dlim = 0;
        m_err = 0; m_pref = 0; m_left = 0; m_owner = 0;
        p_vld = 1'b0; p_dvld = 1'b0;
    endtask

    // One clock: check at the negedge, advance the model, then drive the next
    // cycle's inputs just after the posedge.
    task automatic cycle();
        int e [2];
        int g, use_v, use_d, drop;
        @(negedge clock);
        e[0] = 0; e[1] = 0;
        if (!reset && m_init == 0 && m_left == 0) begin
            for (int i = 0; i < 2; i++)
                e[i] = int'(r_v[i] && m_vc >= 1 && (!r_hd[i] || m_dc >= nb(r_dl[i])));
        end
        g = -1;
        if (e[0] != 0 && e[1] != 0) g = m_pref;
        else if (e[0] != 0)         g = 0;
        else if (e[1] != 0)         g = 1;

        chk("ack0", ack0, g == 0);
        chk("ack1", ack1, g == 1);
        chk("vc3_valid", vc3_vld, p_vld);
        if (p_vld) chk("vc3_cmd", vc3_cmd, p_cmd);
        chk("dcp3_valid", d_vld, p_dvld);
        if (p_dvld) begin
            chk("dcp3_bus", d_bus, p_dbus);
            chk("dcp3_bdi", d_bdi, p_dbdi);
        end
        chk("credit_err", credit_err, m_err[0]);
        chk("vc_cnt", dut.vc_cnt, m_vc);
        chk("dc_cnt", dut.dc_cnt, m_dc);

        drop = -1;
        if (reset) begin
            model_reset();
        end else if (m_init != 0) begin
            m_init = 0;
            m_vc   = tlx_afu_vc3_initial_credit;
            m_vlim = m_vc;
            m_dc   = (tlx_afu_dcp3_initial_credit > DCP_MAX) ? DCP_MAX : tlx_afu_dcp3_initial_credit;
            m_dlim = m_dc;
            p_vld  = 1'b0;
            p_dvld = 1'b0;
        end else begin
            use_v = (g >= 0) ? 1 : 0;
            use_d = (g >= 0 && r_hd[g]) ? nb(r_dl[g]) : 0;
            if (tlx_afu_vc3_credit && (m_vc - use_v + 1 > m_vlim)) begin
                m_err = 1; m_vc = m_vc - use_v;
            end else begin
                m_vc = m_vc - use_v + int'(tlx_afu_vc3_credit);
            end
            if (tlx_afu_dcp3_credit && (m_dc - use_d + 1 > m_dlim)) begin
                m_err = 1; m_dc = m_dc - use_d;
            end else begin
                m_dc = m_dc - use_d + int'(tlx_afu_dcp3_credit);
            end
            p_dvld = (m_left > 0) && r_dv[m_owner];
            if (p_dvld) begin
                p_dbus = r_bus[m_owner];
                p_dbdi = r_bdi[m_owner];
                m_left--;
            end
            p_vld = (g >= 0);
            if (g >= 0) begin
                p_cmd  = r_cmd[g];
                m_pref = 1 - g;
                if (r_hd[g]) begin
                    m_left  = nb(r_dl[g]);
                    m_owner = g;
                end
                drop = g;
            end
        end
        @(posedge clock);
        #1;
        if (drop >= 0) r_v[drop] = 1'b0;
        drive();
    endtask

    task automatic phase(input int ivc, input int idc, input int ncyc);
        tlx_afu_vc3_initial_credit  = 4'(ivc);
        tlx_afu_dcp3_initial_credit = 6'(idc);
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        for (int c = 0; c < ncyc; c++) cycle();
    endtask

    task automatic set_knobs(input int rq0, input int rq1, input int hd0, input int hd1,
                             input int dl, input int dv, input int vr, input int dr);
        k_req[0] = rq0; k_req[1] = rq1; k_hd[0] = hd0; k_hd[1] = hd1;
        k_dl = dl; k_dv = dv; k_vret = vr; k_dret = dr; k_ovf = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tlx_afu_vc3_initial_credit  = 4'd0;
        tlx_afu_dcp3_initial_credit = 6'd0;
        tlx_afu_vc3_credit  = 1'b0;
        tlx_afu_dcp3_credit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_v[i] = 1'b0; r_cmd[i] = '0; r_dl[i] = 2'd0; r_hd[i] = 1'b0;
            r_dv[i] = 1'b0; r_bus[i] = '0; r_bdi[i] = 1'b0;
        end
        set_knobs(0, 0, 0, 0, -1, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;

        // Two VC3 credits: two back-to-back acks, third waits for a return.
        set_knobs(100, 0, 0, 0, -1, 0, 0, 0);
        phase(2, 8, 6);
        tlx_afu_vc3_credit = 1'b1;
        cycle();
        for (int c = 0; c < 4; c++) cycle();

        // Both requesting without data: acks alternate.
        set_knobs(100, 100, 0, 0, -1, 0, 100, 0);
        phase(15, 8, 20);

        // Four-beat write with exactly four data credits; req1 waits it out.
        set_knobs(100, 100, 100, 0, 3, 100, 100, 0);
        phase(8, 4, 14);

        // One data credit: req0 (2 beats) waits, req1 proceeds, return unblocks.
        set_knobs(100, 100, 100, 0, 2, 100, 100, 0);
        phase(8, 1, 6);
        tlx_afu_dcp3_credit = 1'b1;
        cycle();
        for (int c = 0; c < 8; c++) cycle();

        // Return at the limit sets the sticky error; then mixed consume/return.
        set_knobs(0, 0, 0, 0, -1, 0, 0, 0);
        phase(4, 8, 2);
        tlx_afu_vc3_credit = 1'b1;
        cycle();
        set_knobs(60, 0, 0, 0, -1, 0, 50, 0);
        k_ovf = 1'b1;
        for (int c = 0; c < 20; c++) cycle();

        // Reset lands after the second of four beats.
        set_knobs(100, 0, 100, 0, 3, 100, 0, 0);
        phase(4, 8, 1);
        for (int c = 0; c < 20 && m_left != 2; c++) cycle();
        chk("beats_left_before_reset", m_left, 2);
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) cycle();

        // Randomised mix, with occasional reset pulses.
        for (int ph = 0; ph < 6; ph++) begin
            set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100),
                      $urandom_range(100), -1, $urandom_range(30, 100),
                      $urandom_range(10, 80), $urandom_range(10, 80));
            k_ovf = (ph == 5);
            phase($urandom_range(1, 15), $urandom_range(1, 63), 0);
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(199) == 0) reset = 1'b1;
                cycle();
                reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
